// File: rtl/cont_checker.sv
// Receive-side checker for free-running up counters: verifies each valid sample
// is the previous sample plus one (mod 2^WIDTH) and reports lock, errors and wraps.
module cont_checker #(
    parameter int WIDTH      = 3,
    parameter int LOCK_COUNT = 2,
    parameter int ALLOW_HOLD = 0
) (
    input  logic             reloj,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] Q_in,
    input  logic             valid,
    output logic             locked,
    output logic             error,
    output logic [7:0]       err_count,
    output logic [7:0]       wraps,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic             error_q, error_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [7:0]       wraps_q, wraps_d;

    logic [WIDTH-1:0] exp_val;
    logic             is_match;
    logic             is_hold;

    always_comb begin
        exp_val  = WIDTH'(prev_q + 1'b1);
        is_match = (Q_in == exp_val);
        // A repeated sample is only a "hold" when holds are tolerated
        is_hold  = (ALLOW_HOLD != 0) && (Q_in == prev_q);

        state_d     = state_q;
        prev_d      = prev_q;
        match_cnt_d = match_cnt_q;
        error_d     = 1'b0;
        err_count_d = err_count_q;
        wraps_d     = wraps_q;

        if (valid) begin
            unique case (state_q)
                S_IDLE: begin
                    prev_d      = Q_in;
                    match_cnt_d = 4'd0;
                    state_d     = S_SYNC;
                end
                S_SYNC: begin
                    if (is_match) begin
                        prev_d      = Q_in;
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_d == LOCK_CNT) begin
                            state_d = S_LOCKED;
                        end
                    end else if (!is_hold) begin
                        prev_d      = Q_in;
                        match_cnt_d = 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (is_match) begin
                        prev_d = Q_in;
                        // prev all-ones plus a match means the counter just wrapped to 0
                        if ((prev_q == '1) && (wraps_q != 8'hFF)) begin
                            wraps_d = wraps_q + 8'd1;
                        end
                    end else if (!is_hold) begin
                        error_d     = 1'b1;
                        prev_d      = Q_in;
                        match_cnt_d = 4'd0;
                        state_d     = S_SYNC;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge reloj or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            match_cnt_q <= 4'd0;
            error_q     <= 1'b0;
            err_count_q <= 8'd0;
            wraps_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_cnt_q <= match_cnt_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
            wraps_q     <= wraps_d;
        end
    end

    assign locked    = (state_q == S_LOCKED);
    assign error     = error_q;
    assign err_count = err_count_q;
    assign wraps     = wraps_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cont_checker.sv
// Directed bench for cont_checker: one strict instance and one hold-tolerant
// instance share the same stimulus; a behavioural 3-bit counter feeds the last test.
module tb_cont_checker;

    logic       reloj;
    logic       reset_L;
    logic       valid;
    logic [2:0] q_drv;
    logic [2:0] cnt_val;
    logic       cnt_en;
    logic       use_cnt;
    logic [2:0] Q_in;

    logic       locked, error;
    logic [7:0] err_count, wraps;
    logic [1:0] state;
    logic       locked_h, error_h;
    logic [7:0] err_count_h, wraps_h;
    logic [1:0] state_h;

    int n_checks = 0;
    int n_fails  = 0;

    assign Q_in = use_cnt ? cnt_val : q_drv;

    cont_checker #(.WIDTH(3), .LOCK_COUNT(2), .ALLOW_HOLD(0)) dut (
        .reloj(reloj), .reset_L(reset_L), .Q_in(Q_in), .valid(valid),
        .locked(locked), .error(error), .err_count(err_count), .wraps(wraps), .state(state)
    );

    cont_checker #(.WIDTH(3), .LOCK_COUNT(2), .ALLOW_HOLD(1)) dut_h (
        .reloj(reloj), .reset_L(reset_L), .Q_in(Q_in), .valid(valid),
        .locked(locked_h), .error(error_h), .err_count(err_count_h), .wraps(wraps_h), .state(state_h)
    );

    initial reloj = 1'b0;
    always #10 reloj = ~reloj;

    // Behavioural cont3bC: output moves 5 time units after each falling edge
    always @(negedge reloj) begin
        #5;
        if (cnt_en) cnt_val = cnt_val + 3'd1;
    end

    task automatic step(input logic [2:0] q, input logic v);
        @(negedge reloj);
        q_drv = q;
        valid = v;
        @(posedge reloj);
        #1;
    endtask

    task automatic do_reset();
        @(negedge reloj);
        #2 reset_L = 1'b0;
        valid = 1'b0;
        @(negedge reloj);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(3'(i * 3), 1'b1);
            n_checks++;
            if ({state, locked, error, err_count, wraps} !== 19'd0) begin
                n_fails++;
                $display("FAIL reset_hold edge %0d: state=%0d locked=%b error=%b err_count=%0d wraps=%0d, required all 0",
                         i, state, locked, error, err_count, wraps);
            end
        end
        @(negedge reloj);
        reset_L = 1'b1;
        valid   = 1'b0;
    endtask

    task automatic test_lock_and_wrap();
        step(3'd0, 1'b1);
        n_checks++;
        if (state !== 2'd1 || locked !== 1'b0) begin
            n_fails++;
            $display("FAIL first_sample: state=%0d locked=%b, required state=1 locked=0", state, locked);
        end
        step(3'd1, 1'b1);
        n_checks++;
        if (state !== 2'd1 || locked !== 1'b0) begin
            n_fails++;
            $display("FAIL second_sample: state=%0d locked=%b, required state=1 locked=0", state, locked);
        end
        step(3'd2, 1'b1);
        n_checks++;
        if (state !== 2'd2 || locked !== 1'b1) begin
            n_fails++;
            $display("FAIL lock_third: state=%0d locked=%b, required state=2 locked=1", state, locked);
        end
        for (int v = 3; v <= 9; v++) begin
            step(3'(v), 1'b1);
            n_checks++;
            if (error !== 1'b0 || locked !== 1'b1) begin
                n_fails++;
                $display("FAIL count_run value %0d: error=%b locked=%b, required error=0 locked=1", v % 8, error, locked);
            end
        end
        n_checks++;
        if (wraps !== 8'd1 || err_count !== 8'd0) begin
            n_fails++;
            $display("FAIL first_wrap: wraps=%0d err_count=%0d, required wraps=1 err_count=0", wraps, err_count);
        end
    endtask

    task automatic test_mismatch_relock();
        step(3'd2, 1'b1);
        step(3'd3, 1'b1);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fails++;
            $display("FAIL locked_at_3: locked=%b, required 1", locked);
        end
        step(3'd5, 1'b1);
        n_checks++;
        if (error !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || state !== 2'd1) begin
            n_fails++;
            $display("FAIL mismatch: error=%b err_count=%0d locked=%b state=%0d, required 1/1/0/1",
                     error, err_count, locked, state);
        end
        step(3'd6, 1'b1);
        n_checks++;
        if (error !== 1'b0 || locked !== 1'b0 || state !== 2'd1) begin
            n_fails++;
            $display("FAIL error_one_cycle: error=%b locked=%b state=%0d, required 0/0/1", error, locked, state);
        end
        step(3'd7, 1'b1);
        n_checks++;
        if (locked !== 1'b1 || err_count !== 8'd1 || error !== 1'b0) begin
            n_fails++;
            $display("FAIL relock: locked=%b err_count=%0d error=%b, required 1/1/0", locked, err_count, error);
        end
    endtask

    task automatic test_valid_gap();
        logic [2:0] gap_vals [3];
        gap_vals = '{3'd2, 3'd0, 3'd7};
        for (int v = 0; v <= 4; v++) step(3'(v), 1'b1);
        n_checks++;
        if (locked !== 1'b1 || wraps !== 8'd2) begin
            n_fails++;
            $display("FAIL locked_at_4: locked=%b wraps=%0d, required 1/2", locked, wraps);
        end
        for (int i = 0; i < 3; i++) begin
            step(gap_vals[i], 1'b0);
            n_checks++;
            if (error !== 1'b0 || locked !== 1'b1 || state !== 2'd2) begin
                n_fails++;
                $display("FAIL valid_low %0d: error=%b locked=%b state=%0d, required 0/1/2", i, error, locked, state);
            end
        end
        step(3'd5, 1'b1);
        n_checks++;
        if (error !== 1'b0 || locked !== 1'b1 || err_count !== 8'd1) begin
            n_fails++;
            $display("FAIL resume_after_gap: error=%b locked=%b err_count=%0d, required 0/1/1", error, locked, err_count);
        end
    endtask

    task automatic test_async_reset();
        @(negedge reloj);
        #2 reset_L = 1'b0;
        #1;
        n_checks++;
        if ({state, locked, error, err_count, wraps} !== 19'd0 ||
            {state_h, locked_h, error_h, err_count_h, wraps_h} !== 19'd0) begin
            n_fails++;
            $display("FAIL async_reset: state=%0d locked=%b err_count=%0d wraps=%0d (hold inst state=%0d), required all 0",
                     state, locked, err_count, wraps, state_h);
        end
        @(negedge reloj);
        reset_L = 1'b1;
        valid   = 1'b0;
    endtask

    task automatic test_err_saturation();
        logic [2:0] p;
        int         exp_err;
        step(3'd0, 1'b1);
        step(3'd1, 1'b1);
        step(3'd2, 1'b1);
        p       = 3'd2;
        exp_err = 0;
        for (int i = 0; i < 300; i++) begin
            step(p + 3'd3, 1'b1);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            n_checks++;
            if (error !== 1'b1 || err_count !== 8'(exp_err)) begin
                n_fails++;
                $display("FAIL err_sat mismatch %0d: error=%b err_count=%0d, required 1/%0d", i, error, err_count, exp_err);
            end
            step(p + 3'd4, 1'b1);
            step(p + 3'd5, 1'b1);
            p = p + 3'd5;
        end
        n_checks++;
        if (err_count !== 8'd255 || locked !== 1'b1) begin
            n_fails++;
            $display("FAIL err_sat_final: err_count=%0d locked=%b, required 255/1", err_count, locked);
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(3'd7, 1'b1);
        step(3'd0, 1'b1);
        step(3'd1, 1'b1);
        n_checks++;
        if (locked !== 1'b1 || locked_h !== 1'b1 || wraps !== 8'd0) begin
            n_fails++;
            $display("FAIL hold_lock: locked=%b locked_h=%b wraps=%0d, required 1/1/0", locked, locked_h, wraps);
        end
        step(3'd2, 1'b1);
        step(3'd2, 1'b1);
        n_checks++;
        if (error_h !== 1'b0 || locked_h !== 1'b1) begin
            n_fails++;
            $display("FAIL hold_ignored: error_h=%b locked_h=%b, required 0/1", error_h, locked_h);
        end
        n_checks++;
        if (error !== 1'b1 || err_count !== 8'd1 || state !== 2'd1) begin
            n_fails++;
            $display("FAIL hold_strict: error=%b err_count=%0d state=%0d, required 1/1/1", error, err_count, state);
        end
        step(3'd3, 1'b1);
        n_checks++;
        if (error_h !== 1'b0 || locked_h !== 1'b1 || err_count_h !== 8'd0 || error !== 1'b0 || state !== 2'd1) begin
            n_fails++;
            $display("FAIL hold_after: error_h=%b locked_h=%b err_count_h=%0d error=%b state=%0d, required 0/1/0/0/1",
                     error_h, locked_h, err_count_h, error, state);
        end
    endtask

    task automatic test_counter_drive();
        do_reset();
        @(negedge reloj);
        cnt_en  = 1'b0;
        cnt_val = 3'd0;
        use_cnt = 1'b1;
        valid   = 1'b1;
        @(posedge reloj);
        #1;
        cnt_en = 1'b1;
        n_checks++;
        if (state !== 2'd1 || locked !== 1'b0) begin
            n_fails++;
            $display("FAIL cnt_edge1: state=%0d locked=%b, required 1/0", state, locked);
        end
        for (int k = 2; k <= 40; k++) begin
            @(posedge reloj);
            #1;
            n_checks++;
            if (locked !== (k >= 3) || error !== 1'b0) begin
                n_fails++;
                $display("FAIL cnt_edge %0d: locked=%b error=%b, required %b/0", k, locked, error, (k >= 3));
            end
            if (k == 35) begin
                n_checks++;
                if (wraps !== 8'd4 || err_count !== 8'd0) begin
                    n_fails++;
                    $display("FAIL cnt_wraps: wraps=%0d err_count=%0d, required 4/0", wraps, err_count);
                end
            end
        end
        @(negedge reloj);
        valid   = 1'b0;
        cnt_en  = 1'b0;
        use_cnt = 1'b0;
    endtask

    initial begin
        reset_L = 1'b0;
        valid   = 1'b0;
        q_drv   = 3'd0;
        cnt_val = 3'd0;
        cnt_en  = 1'b0;
        use_cnt = 1'b0;
        test_reset();
        test_lock_and_wrap();
        test_mismatch_relock();
        test_valid_gap();
        test_async_reset();
        test_err_saturation();
        test_hold();
        test_counter_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cont_checker.md
Name: cont_checker

Overview:
- Receive-side companion to the team's free-running 3-bit up counters (cont3bC family).
- Samples a counter's output bus and checks that each sample equals the previous one plus 1, modulo 2^WIDTH.
- Reports lock status, a one-cycle error pulse, a saturating error count and a count of wrap-arounds.
- Instantiated in benches beside the counter under test, so a bench can self-check without reading $monitor output by eye.

Parameters:
- WIDTH, 3, width of the counter bus under check.
- LOCK_COUNT, 2, consecutive correct increments needed to enter LOCKED (range 1..15).
- ALLOW_HOLD, 0, if 1 a sample equal to the previous one is ignored; if 0 it is a mismatch.

Ports:
- reloj  input  1  clock; all sampling on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- Q_in  input  WIDTH  counter value under check.
- valid  input  1  Q_in is sampled only on edges where valid=1.
- locked  output  1  high while state=LOCKED.
- error  output  1  one-cycle pulse on a mismatch detected while LOCKED.
- err_count  output  8  saturating count of LOCKED mismatches.
- wraps  output  8  saturating count of max-to-0 transitions seen while LOCKED.
- state  output  2  0=IDLE, 1=SYNC, 2=LOCKED (3 unused).

Behaviour:
- Reset:
  - reset_L=0 forces state=IDLE, locked=0, error=0, err_count=0, wraps=0 and internal prev/match_cnt=0, immediately and without waiting for a clock edge.
  - Release takes effect at the first rising edge with reset_L=1.
  - Reset mid-operation discards all history.
- Registering: all outputs are registered. Each takes its new value at the rising edge that samples the triggering Q_in and holds it for that cycle.
- valid=0: no change to prev, match_cnt, state or counters. error is 0 in the following cycle.
- Expected value: exp = prev + 1, truncated to WIDTH bits, so max+1 wraps to 0.
- IDLE:
  - First valid sample: prev <= Q_in, match_cnt <= 0, go to SYNC.
- SYNC:
  - Q_in==exp: prev <= Q_in and match_cnt increments. If the new match_cnt equals LOCK_COUNT, go to LOCKED and set locked=1 on that same edge.
  - Q_in==prev with ALLOW_HOLD=1: ignored, no change.
  - Otherwise: prev <= Q_in, match_cnt <= 0, stay in SYNC, no error pulse.
- LOCKED:
  - Q_in==exp: prev <= Q_in. If prev was all-ones and Q_in=0, wraps increments, saturating at 255.
  - Q_in==prev with ALLOW_HOLD=1: ignored.
  - Otherwise (mismatch):
    - error=1 for exactly one cycle.
    - err_count increments, saturating at 255.
    - prev <= Q_in, match_cnt <= 0, go to SYNC, locked=0.
- Error and relock: error never asserts outside LOCKED. A back-to-back mismatch in SYNC produces no further pulses.
- Lock latency: with LOCK_COUNT=2, locked rises on the edge that samples the 3rd sample of a correct run.
- Counter widths: err_count and wraps are plain 8-bit and never roll over.

Test Plan:
1. reset_L=0 while Q_in toggles and valid=1 for 5 edges -> state=0, locked=0, error=0, err_count=0, wraps=0. Assert reset_L=0 between edges while LOCKED -> all outputs 0 before the next edge.
2. valid=1, Q_in=0,1,2 on consecutive edges -> state 1 after edge 1, locked=1 after edge 3. Continue 3..7,0,1 -> wraps=1, err_count=0, error never high.
3. Locked at 3, then feed 5 -> error=1 for one cycle, err_count=1, locked=0, state=1. Feed 6, 7 -> locked=1 after the edge sampling 7, err_count still 1.
4. Locked at 4, valid=0 for 3 edges with Q_in=2,0,7, then valid=1 with Q_in=5 -> no error, locked stays 1.
5. Alternate relock and mismatch for 300 mismatches -> err_count=255 and stays 255. ALLOW_HOLD=1 with Q_in=2,2,3 while locked -> no error; same sequence with ALLOW_HOLD=0 -> error pulse at the second 2.
6. Drive Q_in from a cont3bC instance (Q changes 5 time units after the falling edge), valid=1, for 40 edges -> locked=1 from edge 3, wraps=4 after edge 35, err_count=0.
